// File: rtl/sram_port_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_port_ctrl
// Brief    : 64-bit valid/ready request stream to a 64x128 single-port SRAM
//            macro, with post-reset zero-fill and a 2-entry response buffer.
// Revision : 1.0
// ============================================================================
module sram_port_ctrl #(
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_wen,
  input  logic [9:0]   req_addr,
  input  logic [63:0]  req_wdata,
  input  logic [7:0]   req_wstrb,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_wen,
  output logic [63:0]  rsp_rdata,
  output logic         init_done,
  output logic         sram_cen,
  output logic         sram_wen,
  output logic [127:0] sram_bwen,
  output logic [5:0]   sram_a,
  output logic [127:0] sram_d,
  input  logic [127:0] sram_q
);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [63:0] ONES64 = '1;

  state_t      state;
  state_t      state_next;
  logic [5:0]  init_cnt;

  logic        s1_valid;
  logic        s1_wen;
  logic        s1_half;

  logic        buf_wen  [2];
  logic [63:0] buf_data [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  buf_count;

  logic        fire;
  logic        pop;
  logic [2:0]  occupancy;
  logic [63:0] push_data;
  logic [63:0] lane_mask;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[2:0];

  assign rsp_valid = (buf_count != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign occupancy = {1'b0, buf_count} + {2'b00, s1_valid} - {2'b00, pop};

  // Accept only while a slot is guaranteed for this request and the one in s1.
  assign req_ready = !RST && (state == ST_RUN) && (occupancy <= 3'd1);
  assign fire      = req_valid && req_ready;

  assign rsp_wen   = rsp_valid && buf_wen[rd_ptr];
  assign rsp_rdata = rsp_valid ? buf_data[rd_ptr] : 64'd0;

  // Q is only meaningful in the cycle right after a read, which is exactly s1.
  assign push_data = s1_wen ? 64'd0 : (s1_half ? sram_q[127:64] : sram_q[63:0]);

  always_comb begin
    lane_mask = '1;
    for (int i = 0; i < 8; i++) begin
      lane_mask[8*i +: 8] = {8{~req_wstrb[i]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= INIT_ZERO ? ST_INIT : ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    init_done  = 1'b0;
    sram_cen   = 1'b1;
    sram_wen   = 1'b1;
    sram_bwen  = '1;
    sram_a     = 6'd0;
    sram_d     = '0;
    if (!RST) begin
      case (state)
        ST_INIT: begin
          sram_cen  = 1'b0;
          sram_wen  = 1'b0;
          sram_bwen = '0;
          sram_a    = init_cnt;
          if (init_cnt == 6'd63) begin
            state_next = ST_RUN;
          end
        end
        ST_RUN: begin
          init_done = 1'b1;
          if (fire) begin
            sram_cen = 1'b0;
            sram_wen = ~req_wen;
            sram_a   = req_addr[9:4];
            sram_d   = {req_wdata, req_wdata};
            if (req_wen) begin
              sram_bwen = req_addr[3] ? {lane_mask, ONES64} : {ONES64, lane_mask};
            end
          end
        end
        default: state_next = ST_INIT;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      init_cnt    <= 6'd0;
      s1_valid    <= 1'b0;
      s1_wen      <= 1'b0;
      s1_half     <= 1'b0;
      rd_ptr      <= 1'b0;
      wr_ptr      <= 1'b0;
      buf_count   <= 2'd0;
      buf_wen[0]  <= 1'b0;
      buf_wen[1]  <= 1'b0;
      buf_data[0] <= 64'd0;
      buf_data[1] <= 64'd0;
    end else begin
      if (state == ST_INIT) begin
        init_cnt <= init_cnt + 6'd1;
      end
      s1_valid <= fire;
      if (fire) begin
        s1_wen  <= req_wen;
        s1_half <= req_addr[3];
      end
      if (s1_valid) begin
        buf_wen[wr_ptr]  <= s1_wen;
        buf_data[wr_ptr] <= push_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      buf_count <= buf_count + {1'b0, s1_valid} - {1'b0, pop};
    end
  end

endmodule
`default_nettype wire
